// File: rtl/jzjpcc_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : jzjpcc_muldiv
// Brief   : Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Revision: 1.0 - initial release
// ============================================================================
module jzjpcc_muldiv #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_execute,
    input  logic [2:0]  funct3_execute,
    input  logic [31:0] rs1_execute,
    input  logic [31:0] rs2_execute,
    input  logic [4:0]  rdAddr_execute,
    input  logic        flush_execute,
    output logic        stall_execute,
    output logic [31:0] result_memory,
    output logic [4:0]  rdAddr_memory,
    output logic        rdWriteEnable_memory
);

    localparam int         c_N    = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] c_LAST = 5'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
            $error("jzjpcc_muldiv: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [2:0]  r_op;
    logic        r_negate;
    logic        r_special;
    logic [4:0]  r_rd;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;

    logic        w_accept;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_overflow;
    logic [31:0] w_special_val;
    logic [31+BITS_PER_CYCLE:0] w_sum;
    logic [31:0] w_rem;
    logic [31:0] w_quo;
    logic [32:0] w_t;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod_neg;
    logic [31:0] w_result;

    assign w_accept      = (r_state == c_IDLE) && start_execute && !flush_execute;
    assign stall_execute = w_accept || ((r_state == c_BUSY) && !flush_execute);

    // Operands with a signed interpretation: rs1 for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM
    assign w_a_neg = rs1_execute[31] && (funct3_execute == 3'b001 || funct3_execute == 3'b010 ||
                                         funct3_execute == 3'b100 || funct3_execute == 3'b110);
    assign w_b_neg = rs2_execute[31] && (funct3_execute == 3'b001 || funct3_execute == 3'b100 ||
                                         funct3_execute == 3'b110);
    assign w_a_mag = w_a_neg ? -rs1_execute : rs1_execute;
    assign w_b_mag = w_b_neg ? -rs2_execute : rs2_execute;

    assign w_div_zero    = funct3_execute[2] && (rs2_execute == 32'd0);
    assign w_overflow    = funct3_execute[2] && !funct3_execute[0] &&
                           (rs1_execute == 32'h8000_0000) && (rs2_execute == 32'hFFFF_FFFF);
    assign w_special_val = w_div_zero ? (funct3_execute[1] ? rs1_execute : 32'hFFFF_FFFF)
                                      : (funct3_execute[1] ? 32'd0 : 32'h8000_0000);

    // Multiply keeps {partial_hi, multiplier_remaining}; divide keeps {remainder, dividend/quotient}
    always_comb begin
        w_acc_next = r_acc;
        w_sum      = '0;
        w_rem      = r_acc[63:32];
        w_quo      = r_acc[31:0];
        w_t        = '0;
        if (!r_op[2]) begin
            w_sum = (32+BITS_PER_CYCLE)'(r_acc[63:32]) +
                    (32+BITS_PER_CYCLE)'(r_opnd) * (32+BITS_PER_CYCLE)'(r_acc[BITS_PER_CYCLE-1:0]);
            w_acc_next = {w_sum, r_acc[31:BITS_PER_CYCLE]};
        end else begin
            for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                w_t   = {w_rem, w_quo[31]};
                w_quo = {w_quo[30:0], 1'b0};
                if (w_t >= {1'b0, r_opnd}) begin
                    w_rem    = 32'(w_t - {1'b0, r_opnd});
                    w_quo[0] = 1'b1;
                end else begin
                    w_rem = w_t[31:0];
                end
            end
            w_acc_next = {w_rem, w_quo};
        end
    end

    assign w_prod_neg = -r_acc;

    always_comb begin
        w_result = r_acc[31:0];
        if (!r_special) begin
            case (r_op)
                3'b000:                 w_result = r_acc[31:0];
                3'b001, 3'b010, 3'b011: w_result = r_negate ? w_prod_neg[63:32] : r_acc[63:32];
                3'b100, 3'b101:         w_result = r_negate ? -r_acc[31:0] : r_acc[31:0];
                default:                w_result = r_negate ? -r_acc[63:32] : r_acc[63:32];
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= c_IDLE;
            r_count              <= '0;
            r_op                 <= '0;
            r_negate             <= 1'b0;
            r_special            <= 1'b0;
            r_rd                 <= '0;
            r_opnd               <= '0;
            r_acc                <= '0;
            result_memory        <= '0;
            rdAddr_memory        <= '0;
            rdWriteEnable_memory <= 1'b0;
        end else begin
            rdWriteEnable_memory <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op      <= funct3_execute;
                        r_rd      <= rdAddr_execute;
                        r_count   <= '0;
                        r_negate  <= (funct3_execute == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
                        r_special <= w_div_zero || w_overflow;
                        r_opnd    <= funct3_execute[2] ? w_b_mag : w_a_mag;
                        if (w_div_zero || w_overflow) begin
                            r_acc   <= {32'd0, w_special_val};
                            r_state <= c_DONE;
                        end else begin
                            r_acc   <= {32'd0, funct3_execute[2] ? w_a_mag : w_b_mag};
                            r_state <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    if (flush_execute) begin
                        r_state <= c_IDLE;
                        r_count <= '0;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_count == c_LAST) begin
                            r_state <= c_DONE;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 5'd1;
                        end
                    end
                end
                c_DONE: begin
                    if (!flush_execute) begin
                        result_memory        <= w_result;
                        rdAddr_memory        <= r_rd;
                        rdWriteEnable_memory <= (r_rd != 5'd0);
                    end
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_jzjpcc_muldiv
// Brief   : Directed and reference-model bench for jzjpcc_muldiv at all four
//           BITS_PER_CYCLE values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jzjpcc_muldiv;

    logic        clock;
    logic        reset;
    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [4:0]  r_rd;
    logic        r_flush;
    logic        r_start [4];
    logic        w_stall [4];
    logic [31:0] w_res   [4];
    logic [4:0]  w_rda   [4];
    logic        w_wen   [4];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        jzjpcc_muldiv #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clock                (clock),
            .reset                (reset),
            .start_execute        (r_start[g]),
            .funct3_execute       (r_funct3),
            .rs1_execute          (r_rs1),
            .rs2_execute          (r_rs2),
            .rdAddr_execute       (r_rd),
            .flush_execute        (r_flush),
            .stall_execute        (w_stall[g]),
            .result_memory        (w_res[g]),
            .rdAddr_memory        (w_rda[g]),
            .rdWriteEnable_memory (w_wen[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op on DUT d; count stall cycles and write strobes over a bounded window
    task automatic run_op(input int d, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_stall, input string tag);
        int n_st;
        int n_we;
        int wcyc;
        n_st = 0;
        n_we = 0;
        wcyc = 0;
        @(negedge clock);
        r_start[d] = 1'b1;
        r_funct3   = f;
        r_rs1      = a;
        r_rs2      = b;
        r_rd       = rd;
        for (int c = 1; c <= exp_stall + 3; c++) begin
            #1;
            if (w_stall[d]) n_st++;
            @(posedge clock);
            #1;
            r_start[d] = 1'b0;
            if (w_wen[d]) begin
                n_we++;
                wcyc = c;
            end
            @(negedge clock);
        end
        chk({tag, ".stall"},  32'(n_st), 32'(exp_stall));
        chk({tag, ".nwen"},   32'(n_we), (rd != 0) ? 32'd1 : 32'd0);
        chk({tag, ".wcyc"},   32'(wcyc), (rd != 0) ? 32'(exp_stall + 1) : 32'd0);
        chk({tag, ".result"}, w_res[d], exp);
        chk({tag, ".rd"},     32'(w_rda[d]), 32'(rd));
    endtask

    task automatic start_and_wait(input int d, input int iters);
        @(negedge clock);
        r_start[d] = 1'b1;
        r_funct3   = 3'd0;
        r_rs1      = 32'h1234_5678;
        r_rs2      = 32'h09AB_CDEF;
        r_rd       = 5'd7;
        @(posedge clock);
        #1;
        r_start[d] = 1'b0;
        repeat (iters) @(posedge clock);
    endtask

    task automatic quiet_window(input int d, input int cycles, input string tag);
        int n_st;
        int n_we;
        n_st = 0;
        n_we = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (w_stall[d]) n_st++;
            if (w_wen[d]) n_we++;
        end
        chk({tag, ".stall"}, 32'(n_st), 32'd0);
        chk({tag, ".nwen"},  32'(n_we), 32'd0);
    endtask

    initial begin
        int          n;
        int          exp_stall;
        logic [31:0] a;
        logic [31:0] b;
        logic        special;

        reset    = 1'b1;
        r_flush  = 1'b0;
        r_funct3 = '0;
        r_rs1    = '0;
        r_rs2    = '0;
        r_rd     = '0;
        for (int i = 0; i < 4; i++) r_start[i] = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset.result", w_res[0], 32'd0);
        chk("reset.rd",     32'(w_rda[0]), 32'd0);
        chk("reset.wen",    32'(w_wen[0]), 32'd0);
        chk("reset.stall",  32'(w_stall[0]), 32'd0);
        reset = 1'b0;

        // Multiply directed vectors, one bit per cycle
        run_op(0, 3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, "mul");
        run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, "mulh");
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 33, "mulhsu");

        // Divide directed vectors, four bits per cycle
        run_op(2, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 9, "div");
        run_op(2, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 9, "rem");
        run_op(2, 3'd5, 32'd100,       32'd7, 5'd3, 32'd14,        9, "divu");
        run_op(2, 3'd7, 32'd100,       32'd7, 5'd4, 32'd2,         9, "remu");

        // Special cases resolved at acceptance
        run_op(2, 3'd4, 32'h1234,      32'd0,         5'd10, 32'hFFFF_FFFF, 1, "div0");
        run_op(2, 3'd7, 32'h1234,      32'd0,         5'd11, 32'h1234,      1, "remu0");
        run_op(2, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, "divovf");
        run_op(2, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1, "removf");

        // rd = 0 completes on schedule without a write strobe
        run_op(2, 3'd5, 32'd9, 32'd3, 5'd0, 32'd3, 9, "rd0");

        // Flush while iterating
        start_and_wait(0, 10);
        @(negedge clock);
        r_flush = 1'b1;
        #1;
        chk("flush.stall", 32'(w_stall[0]), 32'd0);
        @(posedge clock);
        #1;
        chk("flush.wen", 32'(w_wen[0]), 32'd0);
        r_flush = 1'b0;
        quiet_window(0, 40, "flush.after");
        run_op(0, 3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 33, "mul_after_flush");

        // Flush beats start in IDLE
        @(negedge clock);
        r_start[1] = 1'b1;
        r_flush    = 1'b1;
        #1;
        chk("idleflush.stall", 32'(w_stall[1]), 32'd0);
        @(posedge clock);
        #1;
        r_start[1] = 1'b0;
        r_flush    = 1'b0;
        quiet_window(1, 20, "idleflush.after");

        // Asynchronous reset mid-operation
        start_and_wait(0, 10);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("areset.result", w_res[0], 32'd0);
        chk("areset.rd",     32'(w_rda[0]), 32'd0);
        chk("areset.wen",    32'(w_wen[0]), 32'd0);
        chk("areset.stall",  32'(w_stall[0]), 32'd0);
        #2;
        reset = 1'b0;
        quiet_window(0, 40, "areset.after");

        // All ops at all widths against the reference model
        for (int d = 0; d < 4; d++) begin
            n = 32 >> d;
            for (int f = 0; f < 8; f++) begin
                for (int k = 0; k < 2; k++) begin
                    a = $urandom;
                    b = (k == 0) ? $urandom : ($urandom & 32'h0000_00FF);
                    if (k == 1 && f[0]) b = b | 32'h8000_0000;
                    special = (f >= 4) && ((b == 0) ||
                              ((f == 4 || f == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
                    exp_stall = special ? 1 : n + 1;
                    run_op(d, 3'(f), a, b, 5'($urandom_range(1, 31)), ref_op(3'(f), a, b),
                           exp_stall, $sformatf("rnd.d%0d.f%0d.k%0d", d, f, k));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jzjpcc_muldiv.md
# jzjpcc_muldiv

Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage of the pipelined core. It accepts one M-extension operation per request, holds the pipeline with a stall signal while iterating, then registers the result, rd address and write enable into the memory stage. Throughput/area trade-off is set by a bits-per-cycle parameter.

## Interface

- BITS_PER_CYCLE, 1, result bits retired per iteration; legal values are 1, 2, 4 and 8, and any other value is an elaboration error. N = 32 / BITS_PER_CYCLE iterations.
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- start_execute  in  1  execute stage holds an M-extension instruction
- funct3_execute  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_execute  in  32  operand A (dividend or multiplicand)
- rs2_execute  in  32  operand B (divisor or multiplier)
- rdAddr_execute  in  5  destination register
- flush_execute  in  1  kill the in-flight operation (branch or trap)
- stall_execute  out  1  combinational; holds fetch, decode and execute
- result_memory  out  32  registered result to the memory stage
- rdAddr_memory  out  5  registered destination
- rdWriteEnable_memory  out  1  registered one-cycle write strobe

## Operation

- States: IDLE, BUSY, DONE.
- IDLE, start_execute=1, flush_execute=0:
  - Latch the op, operand magnitudes, sign-fix flags and rd on the edge.
  - Go to BUSY, or straight to DONE for special cases.
- Signed ops (MULH, MULHSU, DIV, REM) iterate on magnitudes.
  - MULH/MULHSU product sign = XOR of the operand signs; MULHSU treats rs2 as unsigned.
  - DIV quotient sign = XOR of the operand signs. REM remainder takes the sign of rs1.
  - Negation is applied in DONE.
- Multiply: shift-add over a 64-bit accumulator, BITS_PER_CYCLE multiplier bits per iteration.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring, BITS_PER_CYCLE quotient bits per iteration, MSB first.
- Special cases, resolved at acceptance (IDLE→DONE, no iterations):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- BUSY: an iteration counter runs from 0 to N-1. On the edge at count N-1, go to DONE.
- DONE: the final result is combinational and start_execute is ignored. On the next edge:
  - Load result_memory and rdAddr_memory.
  - rdWriteEnable_memory = (rd != 0).
  - Return to IDLE.
- Outside the write edge: rdWriteEnable_memory=0; result_memory and rdAddr_memory hold their values.
- stall_execute = (IDLE & start_execute & !flush_execute) | BUSY. It is 0 in DONE, so the pipeline advances on the write edge.
- flush_execute:
  - In BUSY or DONE: next edge goes to IDLE, no write strobe; stall_execute=0 in that cycle.
  - In IDLE with start_execute=1: flush wins and nothing is accepted.
- Reset, any state: IDLE, counter 0, result_memory=0, rdAddr_memory=0, rdWriteEnable_memory=0. No write for an aborted operation.

## Timing

- Acceptance edge = E0. Normal op: E1..EN iterate, DONE after EN, write strobe after E(N+1).
- stall_execute is high for N+1 cycles: the cycle before E0 through the cycle before EN.
- Special case: DONE after E0, strobe after E1; stall_execute is high for 1 cycle.
- BITS_PER_CYCLE=1: stall 33 cycles, write after E33. BITS_PER_CYCLE=4: stall 9 cycles, write after E9.
- Back-to-back requests: the next instruction can be accepted on the edge after the write edge at the earliest.
- rdWriteEnable_memory is high for exactly one cycle per completed operation.

## Test plan

- BITS_PER_CYCLE=1, MUL 7 × 0xFFFFFFFD, rd=5:
  - stall_execute high 33 cycles.
  - After E33: result_memory=0xFFFFFFEB, rdAddr_memory=5, rdWriteEnable_memory=1 for one cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- BITS_PER_CYCLE=4, DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each has stall 9 cycles.
- Special cases, each with stall 1 cycle and write after E1:
  - DIV 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Abort cases:
  - Assert flush_execute at iteration 10 → IDLE next edge, no strobe, stall_execute=0; a new MUL 3×4 accepted afterwards yields 12.
  - Same abort via asynchronous reset → all outputs 0 immediately.
- rd=0: DIVU 9/3 completes on schedule with rdWriteEnable_memory held 0. Random signed/unsigned operands for all 8 ops on all 4 BITS_PER_CYCLE values match the reference model.
